contr_decode_pipe: RTL

CONTR_DECODE_PIPE -- requirements
Module: contr_decode_pipe

---
 rtl/contr_decode_pipe.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/contr_decode_pipe.sv
// contr_decode_pipe: RV32 instruction decoder followed by a small FIFO of decoded entries.
//
// Each instruction is decoded combinationally as it is pushed. Only the control bundle and
// the PC are stored; the raw word is never kept. The outputs always come from the head
// entry, and they read as zero whenever the queue is empty.
//
// Optional feature: define CONTR_RV32M_EN to accept RV32M (OP opcode with funct7 = 0000001).
// These entries carry an MDU enable and the MDU operation (funct3) on out_mdu_en/out_mdu_op.
// Without the macro those ports do not exist and the encoding decodes as illegal.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   flush             synchronous discard of every queued entry (same-cycle push dropped)
//   in_valid/in_ready upstream handshake; in_ready = (occ < DEPTH)
//   in_instr, in_pc   raw instruction word and its PC
//   out_valid/ready   downstream handshake; out_valid = (occ != 0)
//   out_pc, out_*     PC and control bundle of the head entry
//   out_illegal       head entry holds an unsupported encoding
//   occ               current entry count
//
// Control encodings
//   extop  : 000 I, 001 U, 010 S, 011 B, 100 J
//   ALUAsrc: 0 rs1, 1 PC        ALUBsrc: 00 rs2, 01 imm, 10 constant 4
//   ALUctr : 0000 add, 1000 sub, 0001 sll, 0010 slt, 1010 sltu, 0011 copy B,
//            0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and
//   branch : 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt(u), 111 bge(u)
//   memop  : load/store funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)

module contr_decode_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [2:0]                 out_extop,
  output logic                       out_regwr,
  output logic                       out_ALUAsrc,
  output logic [1:0]                 out_ALUBsrc,
  output logic [3:0]                 out_ALUctr,
  output logic [2:0]                 out_branch,
  output logic                       out_MemtoReg,
  output logic                       out_memwr,
  output logic [2:0]                 out_memop,
  output logic                       out_illegal,
`ifdef CONTR_RV32M_EN
  output logic                       out_mdu_en,
  output logic [2:0]                 out_mdu_op,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0] extop;
    logic       regwr;
    logic       alua;
    logic [1:0] alub;
    logic [3:0] aluctr;
    logic [2:0] branch;
    logic       memtoreg;
    logic       memwr;
    logic [2:0] memop;
    logic       illegal;
`ifdef CONTR_RV32M_EN
    logic       mdu_en;
    logic [2:0] mdu_op;
`endif
  } ctl_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctl_t       dec;

  assign opcode = in_instr[6:2];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // ALU operation for OP / OP-IMM. 'alt' is instr[30]; it selects sub only for register
  // forms, while sra/srl is selected by it in both forms.
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    logic [3:0] r;
    case (f3)
      3'b000:  r = (is_reg && alt) ? 4'b1000 : 4'b0000;
      3'b001:  r = 4'b0001;
      3'b010:  r = 4'b0010;
      3'b011:  r = 4'b1010;
      3'b100:  r = 4'b0100;
      3'b101:  r = alt ? 4'b1101 : 4'b0101;
      3'b110:  r = 4'b0110;
      default: r = 4'b0111;
    endcase
    return r;
  endfunction

  // Illegal encodings keep every other control at zero, so no write or branch can leak out.
  always_comb begin
    dec = '0;
    if (in_instr == 32'h0) begin
      // All-zero word is a pipeline bubble: no controls, not illegal.
    end else if (in_instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        5'b01101: begin // lui
          dec.extop  = 3'b001;
          dec.regwr  = 1'b1;
          dec.alub   = 2'b01;
          dec.aluctr = 4'b0011;
        end
        5'b00101: begin // auipc
          dec.extop  = 3'b001;
          dec.regwr  = 1'b1;
          dec.alua   = 1'b1;
          dec.alub   = 2'b01;
        end
        5'b00100: begin // op-imm
          dec.regwr  = 1'b1;
          dec.alub   = 2'b01;
          dec.aluctr = alu_fn(funct3, in_instr[30], 1'b0);
        end
        5'b01100: begin // op
          if (funct7 == 7'b0000001) begin
`ifdef CONTR_RV32M_EN
            dec.regwr  = 1'b1;
            dec.mdu_en = 1'b1;
            dec.mdu_op = funct3;
`else
            dec.illegal = 1'b1;
`endif
          end else begin
            dec.regwr  = 1'b1;
            dec.aluctr = alu_fn(funct3, in_instr[30], 1'b1);
          end
        end
        5'b00000: begin // load
          dec.regwr    = 1'b1;
          dec.alub     = 2'b01;
          dec.memtoreg = 1'b1;
          dec.memop    = funct3;
        end
        5'b01000: begin // store
          dec.extop = 3'b010;
          dec.alub  = 2'b01;
          dec.memwr = 1'b1;
          dec.memop = funct3;
        end
        5'b11000: begin // branch; signedness of the compare comes from funct3[1]
          dec.extop  = 3'b011;
          dec.aluctr = funct3[1] ? 4'b1010 : 4'b0010;
          dec.branch = {1'b1, funct3[2], funct3[0]};
        end
        5'b11011: begin // jal
          dec.extop  = 3'b100;
          dec.regwr  = 1'b1;
          dec.alua   = 1'b1;
          dec.alub   = 2'b10;
          dec.branch = 3'b001;
        end
        5'b11001: begin // jalr
          dec.regwr  = 1'b1;
          dec.alua   = 1'b1;
          dec.alub   = 2'b10;
          dec.branch = 3'b010;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Queue
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  ctl_t            ctl_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q  [DEPTH];
  logic            push, pop;

  // Wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign in_ready  = (occ_q < OccW'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign occ       = occ_q;

  // A push during flush is dropped. in_ready/out_valid already block overflow/underflow.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ctl_mem_q[wr_ptr_q] <= dec;
      pc_mem_q[wr_ptr_q]  <= in_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs
  // ---------------------------------------------------------------------------
  ctl_t            head;
  logic [PC_W-1:0] head_pc;

  always_comb begin
    head    = '0;
    head_pc = '0;
    if (out_valid) begin
      head    = ctl_mem_q[rd_ptr_q];
      head_pc = pc_mem_q[rd_ptr_q];
    end
  end

  assign out_pc       = head_pc;
  assign out_extop    = head.extop;
  assign out_regwr    = head.regwr;
  assign out_ALUAsrc  = head.alua;
  assign out_ALUBsrc  = head.alub;
  assign out_ALUctr   = head.aluctr;
  assign out_branch   = head.branch;
  assign out_MemtoReg = head.memtoreg;
  assign out_memwr    = head.memwr;
  assign out_memop    = head.memop;
  assign out_illegal  = head.illegal;
`ifdef CONTR_RV32M_EN
  assign out_mdu_en   = head.mdu_en;
  assign out_mdu_op   = head.mdu_op;
`endif

endmodule
